// File: rtl/decode_pipe.sv
// MIPS decode stage: one registered output slot with valid/ready handshakes and a
// mult->mflo interlock countdown. Define DECODE_ILLEGAL_TRAP_EN to add the illegal output.
module decode_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int MULT_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            dest_sel,
    output logic [3:0]            alu_ctrl,
    output logic                  flag_sw,
    output logic [1:0]            flag_lw,
    output logic                  flag_r,
    output logic                  flag_i,
    output logic [1:0]            flag_j,
    output logic [1:0]            srcb_sel,
    output logic                  mult_op,
    output logic                  mflo_flag,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                  illegal,
`endif
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [DATA_WIDTH-1:0] imm_ext,
    output logic [25:0]           jtarget,
    output logic                  mult_busy
);

    typedef struct packed {
        logic [1:0] dest_sel;
        logic [3:0] alu_ctrl;
        logic       flag_sw;
        logic [1:0] flag_lw;
        logic       flag_r;
        logic       flag_i;
        logic [1:0] flag_j;
        logic [1:0] srcb_sel;
        logic       mult_op;
        logic       mflo_flag;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } dec_t;

    dec_t        dec, dec_q;
    logic [31:0] instr_q;
    logic [3:0]  mult_cnt;
    logic        is_mult, is_mflo, mflo_stall, accept, sext;
    logic [5:0]  op, funct, op_q;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    assign is_mult    = (op == 6'h00) && (funct == 6'h18);
    assign is_mflo    = (op == 6'h00) && (funct == 6'h12);
    assign mflo_stall = in_valid && is_mflo && (mult_cnt != 4'd0);
    assign in_ready   = (!out_valid || out_ready) && !mflo_stall;
    assign accept     = in_valid && in_ready;
    assign mult_busy  = (mult_cnt != 4'd0);

    always_comb begin
        dec          = '0;
        dec.alu_ctrl = 4'd2;
        case (op)
            6'h00: begin
                dec.flag_r   = 1'b1;
                dec.dest_sel = 2'd1;
                case (funct)
                    6'h00: dec.alu_ctrl = 4'd8;
                    6'h08: begin dec.alu_ctrl = 4'd0; dec.flag_j = 2'd2; end
                    6'h12: begin dec.alu_ctrl = 4'd0; dec.mflo_flag = 1'b1; end
                    6'h18: begin dec.alu_ctrl = 4'd0; dec.mult_op = 1'b1; end
                    6'h20: dec.alu_ctrl = 4'd2;
                    6'h25: dec.alu_ctrl = 4'd6;
                    6'h2A: dec.alu_ctrl = 4'd12;
                    default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                        dec         = '0;
                        dec.illegal = 1'b1;
`else
                        dec.alu_ctrl = 4'd2;
`endif
                    end
                endcase
            end
            6'h02: dec.alu_ctrl = 4'd0;
            6'h03: begin
                dec.alu_ctrl = 4'd0;
                dec.flag_j   = 2'd1;
                dec.flag_lw  = 2'd2;
                dec.dest_sel = 2'd2;
            end
            6'h04, 6'h05: dec.flag_i = 1'b1;
            6'h08: begin dec.flag_i = 1'b1; dec.srcb_sel = 2'd2; end
            6'h0A: begin dec.flag_i = 1'b1; dec.srcb_sel = 2'd2; dec.alu_ctrl = 4'd12; end
            6'h0C: begin dec.flag_i = 1'b1; dec.srcb_sel = 2'd2; dec.alu_ctrl = 4'd5; end
            6'h0D: begin dec.flag_i = 1'b1; dec.srcb_sel = 2'd2; dec.alu_ctrl = 4'd6; end
            6'h0F: begin dec.flag_i = 1'b1; dec.srcb_sel = 2'd2; dec.alu_ctrl = 4'd11; end
            6'h23: begin dec.flag_i = 1'b1; dec.flag_lw = 2'd1; end
            6'h2B: begin dec.flag_i = 1'b1; dec.flag_sw = 1'b1; end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec         = '0;
                dec.illegal = 1'b1;
`else
                dec.flag_i = 1'b1;
`endif
            end
        endcase
        // j shares the opcode-2 arm above; set its jump flag here to keep the case compact
        if (op == 6'h02) dec.flag_j = 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dec_q     <= '0;
            instr_q   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            dec_q     <= dec;
            instr_q   <= instr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A new mult restarts the interlock window rather than extending it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mult_cnt <= 4'd0;
        else if (accept && is_mult)
            mult_cnt <= 4'(MULT_LATENCY);
        else if (mult_cnt != 4'd0)
            mult_cnt <= mult_cnt - 4'd1;
    end

    assign op_q = instr_q[31:26];
    always_comb begin
        case (op_q)
            6'h04, 6'h05, 6'h08, 6'h0A, 6'h23, 6'h2B: sext = 1'b1;
            default:                                  sext = 1'b0;
        endcase
    end

    assign imm_ext = sext ? {{(DATA_WIDTH-16){instr_q[15]}}, instr_q[15:0]}
                          : {{(DATA_WIDTH-16){1'b0}}, instr_q[15:0]};
    assign rs      = instr_q[25:21];
    assign rt      = instr_q[20:16];
    assign rd      = instr_q[15:11];
    assign shamt   = instr_q[10:6];
    assign jtarget = instr_q[25:0];

    assign dest_sel  = dec_q.dest_sel;
    assign alu_ctrl  = dec_q.alu_ctrl;
    assign flag_sw   = dec_q.flag_sw;
    assign flag_lw   = dec_q.flag_lw;
    assign flag_r    = dec_q.flag_r;
    assign flag_i    = dec_q.flag_i;
    assign flag_j    = dec_q.flag_j;
    assign srcb_sel  = dec_q.srcb_sel;
    assign mult_op   = dec_q.mult_op;
    assign mflo_flag = dec_q.mflo_flag;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal   = dec_q.illegal;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: expected bundles queued on acceptance, compared on output.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr;
    logic [1:0]  dest_sel, flag_lw, flag_j, srcb_sel;
    logic [3:0]  alu_ctrl;
    logic        flag_sw, flag_r, flag_i, mult_op, mflo_flag, mult_busy;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_ext;
    logic [25:0] jtarget;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        logic [3:0]  alu;
        logic [1:0]  dest, srcb, fj, flw;
        logic        fi, fr, fsw, mult, mflo, ill;
        logic [4:0]  rt, rd;
        logic [31:0] imm;
        logic [25:0] jt;
    } exp_t;

    exp_t q[$];

    decode_pipe #(.DATA_WIDTH(32), .MULT_LATENCY(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .dest_sel(dest_sel), .alu_ctrl(alu_ctrl), .flag_sw(flag_sw), .flag_lw(flag_lw),
        .flag_r(flag_r), .flag_i(flag_i), .flag_j(flag_j), .srcb_sel(srcb_sel),
        .mult_op(mult_op), .mflo_flag(mflo_flag),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm_ext(imm_ext),
        .jtarget(jtarget), .mult_busy(mult_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] alu, input logic [1:0] dest, srcb, fj, flw,
                                input logic fi, fr, fsw, mult, mflo, ill,
                                input logic [4:0] rt_e, rd_e, input logic [31:0] imm,
                                input logic [25:0] jt);
        exp_t e;
        e.alu = alu; e.dest = dest; e.srcb = srcb; e.fj = fj; e.flw = flw;
        e.fi = fi; e.fr = fr; e.fsw = fsw; e.mult = mult; e.mflo = mflo; e.ill = ill;
        e.rt = rt_e; e.rd = rd_e; e.imm = imm; e.jt = jt;
        return e;
    endfunction

    // Scoreboard: every bundle the consumer takes is compared with the oldest expectation
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("alu_ctrl", alu_ctrl, e.alu);
                chk("dest_sel", dest_sel, e.dest);
                chk("srcb_sel", srcb_sel, e.srcb);
                chk("flag_j", flag_j, e.fj);
                chk("flag_lw", flag_lw, e.flw);
                chk("flag_i", flag_i, e.fi);
                chk("flag_r", flag_r, e.fr);
                chk("flag_sw", flag_sw, e.fsw);
                chk("mult_op", mult_op, e.mult);
                chk("mflo_flag", mflo_flag, e.mflo);
                chk("rt", rt, e.rt);
                chk("rd", rd, e.rd);
                chk("imm_ext", imm_ext, e.imm);
                chk("jtarget", jtarget, e.jt);
`ifdef DECODE_ILLEGAL_TRAP_EN
                chk("illegal", illegal, e.ill);
`endif
            end
        end
    end

    task automatic send(input logic [31:0] w, input exp_t e, output int stalls);
        int n = 0;
        bit ok = 1'b0;
        instr    = w;
        in_valid = 1'b1;
        while (!ok && n < 40) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        chk("accepted", ok, 1);
        if (ok) q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) chk("latency_1", out_valid, 1);
        stalls = n;
    endtask

    localparam int NT = 16;
    logic [31:0] tw[NT];
    exp_t        te[NT];

    initial begin
        int st;
        exp_t e_mult, e_mflo, e_a, e_b;
        reset = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;

        tw[0]  = 32'h2008FFFF; te[0]  = mk(2, 0,2,0,0, 1,0,0,0,0,0,  8,31, 32'hFFFFFFFF, 26'h008FFFF);
        tw[1]  = 32'h3408FFFF; te[1]  = mk(6, 0,2,0,0, 1,0,0,0,0,0,  8,31, 32'h0000FFFF, 26'h008FFFF);
        tw[2]  = 32'h0C000010; te[2]  = mk(0, 2,0,1,2, 0,0,0,0,0,0,  0, 0, 32'h00000010, 26'h0000010);
        tw[3]  = 32'h30088000; te[3]  = mk(5, 0,2,0,0, 1,0,0,0,0,0,  8,16, 32'h00008000, 26'h0088000);
        tw[4]  = 32'h8C088000; te[4]  = mk(2, 0,0,0,1, 1,0,0,0,0,0,  8,16, 32'hFFFF8000, 26'h0088000);
        tw[5]  = 32'hAC088000; te[5]  = mk(2, 0,0,0,0, 1,0,1,0,0,0,  8,16, 32'hFFFF8000, 26'h0088000);
        tw[6]  = 32'h01095020; te[6]  = mk(2, 1,0,0,0, 0,1,0,0,0,0,  9,10, 32'h00005020, 26'h1095020);
        tw[7]  = 32'h0109502A; te[7]  = mk(12,1,0,0,0, 0,1,0,0,0,0,  9,10, 32'h0000502A, 26'h109502A);
        tw[8]  = 32'h00094080; te[8]  = mk(8, 1,0,0,0, 0,1,0,0,0,0,  9, 8, 32'h00004080, 26'h0094080);
        tw[9]  = 32'h03E00008; te[9]  = mk(0, 1,0,2,0, 0,1,0,0,0,0,  0, 0, 32'h00000008, 26'h3E00008);
        tw[10] = 32'h3C081234; te[10] = mk(11,0,2,0,0, 1,0,0,0,0,0,  8, 2, 32'h00001234, 26'h0081234);
        tw[11] = 32'h1109FFFE; te[11] = mk(2, 0,0,0,0, 1,0,0,0,0,0,  9,31, 32'hFFFFFFFE, 26'h109FFFE);
        tw[12] = 32'h28088000; te[12] = mk(12,0,2,0,0, 1,0,0,0,0,0,  8,16, 32'hFFFF8000, 26'h0088000);
        tw[13] = 32'h08000004; te[13] = mk(0, 0,0,1,0, 0,0,0,0,0,0,  0, 0, 32'h00000004, 26'h0000004);
`ifdef DECODE_ILLEGAL_TRAP_EN
        tw[14] = 32'hFC000000; te[14] = mk(0, 0,0,0,0, 0,0,0,0,0,1,  0, 0, 32'h00000000, 26'h0000000);
        tw[15] = 32'h0000003F; te[15] = mk(0, 0,0,0,0, 0,0,0,0,0,1,  0, 0, 32'h0000003F, 26'h000003F);
`else
        tw[14] = 32'hFC000000; te[14] = mk(2, 0,0,0,0, 1,0,0,0,0,0,  0, 0, 32'h00000000, 26'h0000000);
        tw[15] = 32'h0000003F; te[15] = mk(2, 1,0,0,0, 0,1,0,0,0,0,  0, 0, 32'h0000003F, 26'h000003F);
`endif

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mult_busy", mult_busy, 0);
        chk("rst_alu", alu_ctrl, 0);
        chk("rst_imm", imm_ext, 0);
        chk("rst_jtarget", jtarget, 0);
        chk("rst_dest", dest_sel, 0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // decode table, back-to-back
        for (int i = 0; i < NT; i++) send(tw[i], te[i], st);
        repeat (2) @(posedge clk); #1;
        chk("drain_out_valid", out_valid, 0);

        // mult then mflo: interlock holds mflo for MULT_LATENCY cycles
        e_mult = mk(0, 1,0,0,0, 0,1,0,1,0,0, 9, 0, 32'h00000018, 26'h1090018);
        e_mflo = mk(0, 1,0,0,0, 0,1,0,0,1,0, 0,10, 32'h00005012, 26'h0005012);
        send(32'h01090018, e_mult, st);
        chk("mult_busy_set", mult_busy, 1);
        send(32'h00005012, e_mflo, st);
        chk("mflo_stall_cycles", st, 4);
        repeat (2) @(posedge clk); #1;

        // consumer backpressure for 3 cycles
        e_a = mk(6, 0,2,0,0, 1,0,0,0,0,0, 8, 0, 32'h000000AA, 26'h00800AA);
        e_b = mk(2, 0,2,0,0, 1,0,0,0,0,0, 9, 0, 32'h00000005, 26'h0090005);
        out_ready = 1'b0;
        send(32'h340800AA, e_a, st);
        instr = 32'h20090005; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_imm", imm_ext, 32'h000000AA);
            chk("hold_alu", alu_ctrl, 6);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        q.push_back(e_b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("second_out_valid", out_valid, 1);
        chk("second_alu", alu_ctrl, 2);
        repeat (2) @(posedge clk); #1;

        // reset in the middle of a mult countdown with a bundle pending
        out_ready = 1'b0;
        send(32'h01090018, e_mult, st);
        repeat (2) @(posedge clk); #1;
        chk("pre_rst_busy", mult_busy, 1);
        chk("pre_rst_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", mult_busy, 0);
        chk("mid_rst_mult_op", mult_op, 0);
        chk("mid_rst_rt", rt, 0);
        chk("mid_rst_imm", imm_ext, 0);
        q.delete();
        #1 reset = 1'b1;
        out_ready = 1'b1;
        send(32'h00005012, e_mflo, st);
        chk("post_rst_mflo_stalls", st, 0);
        repeat (3) @(posedge clk); #1;
        chk("scoreboard_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of the extended immediate output (legal range 32..64).
REQ-002 SHALL have parameter MULT_LATENCY, default 4, meaning cycles a mult occupies LO before mflo may issue (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid  input  1  and in_ready  output  1, the instruction handshake.
REQ-006 SHALL have port instr  input  32  MIPS instruction word.
REQ-007 SHALL have ports out_valid  output  1  and out_ready  input  1, the decoded-bundle handshake.
REQ-008 SHALL have outputs dest_sel 2 (0 rt, 1 rd, 2 $31), alu_ctrl 4, flag_sw 1, flag_lw 2, flag_r 1, flag_i 1, flag_j 2, srcb_sel 2, mult_op 1, mflo_flag 1.
REQ-009 SHALL have outputs rs 5, rt 5, rd 5, shamt 5, imm_ext DATA_WIDTH, jtarget 26, all field extracts of the registered instruction.
REQ-010 SHALL have output mult_busy  1  high while the mult countdown is nonzero.

Function
REQ-011 SHALL register the decoded bundle in one output stage; latency from accepted instruction to out_valid is exactly 1 cycle.
REQ-012 SHALL accept an instruction when in_valid && in_ready; in_ready = (!out_valid || out_ready) && !mflo_stall.
REQ-013 SHALL hold all outputs stable while out_valid && !out_ready; out_valid clears when the bundle is taken and no new instruction is accepted.
REQ-014 SHALL decode R-type (opcode 0) as flag_r=1, flag_i=0, dest_sel=1, srcb_sel=0: funct 0x00 alu 8; 0x08 alu 0, flag_j=2; 0x12 alu 0, mflo_flag=1; 0x18 alu 0, mult_op=1; 0x20 alu 2; 0x25 alu 6; 0x2A alu 12; other funct alu 2.
REQ-015 SHALL decode j (0x02) flag_j=1, flag_i=0; jal (0x03) flag_j=1, flag_lw=2, dest_sel=2; both alu 0.
REQ-016 SHALL decode beq/bne (0x04/0x05) alu 2, srcb 0; addi 0x08 alu 2; slti 0x0A alu 12; andi 0x0C alu 5; ori 0x0D alu 6; lui 0x0F alu 11; those five srcb 2; lw 0x23 alu 2, flag_lw=1; sw 0x2B alu 2, flag_sw=1; all flag_i=1, dest_sel=0.
REQ-017 SHALL leave unlisted flags at 0 for every decode; lui SHALL drive flag_sw=0; unknown opcodes decode as I-type, alu 2, flag_j=0 (unless REQ-024).
REQ-018 SHALL sign-extend instr[15:0] to DATA_WIDTH for addi, slti, beq, bne, lw, sw, and zero-extend for andi, ori, lui and all other opcodes.
REQ-019 SHALL load the mult countdown with MULT_LATENCY when a mult is accepted, else decrement by 1 each cycle while nonzero, independent of handshakes.
REQ-020 SHALL assert mflo_stall when instr is mflo, in_valid=1 and countdown != 0; the mflo is accepted the first cycle the countdown reads 0.
REQ-021 SHALL reload (not add to) the countdown on a mult accepted while mult_busy.

Reset
REQ-022 SHALL, on reset low, asynchronously clear out_valid, every decoded output, field output and the countdown to 0; in_ready reads 1 after release.
REQ-023 SHALL discard any pending bundle and mult countdown on reset mid-operation; no output reappears after release.

Configuration
REQ-024 SHALL, with DECODE_ILLEGAL_TRAP_EN defined, add output illegal (1 bit) set with the bundle for unknown opcodes or R-type funct, all other flags 0, alu 0; without it, no port exists and REQ-017 default applies.

Verification
REQ-025 Bench: reset, send addi $t0,$zero,-1 (0x2008FFFF) -> next cycle out_valid=1, alu 2, srcb 2, dest 0, rt 8, imm_ext all ones.
REQ-026 Bench: send ori 0x3408FFFF -> imm_ext = 0x0000FFFF, alu 6; send jal 0x0C000010 -> flag_j 1, flag_lw 2, dest 2, jtarget 0x10.
REQ-027 Bench: mult then mflo back-to-back, MULT_LATENCY=4 -> mflo in_ready=0 for 4 cycles, accepted on the 5th, mflo_flag=1.
REQ-028 Bench: hold out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 -> in_ready=0, outputs unchanged, second instruction emerges 1 cycle after out_ready rises.
REQ-029 Bench: assert reset during mult countdown=2 with out_valid=1 -> all outputs 0 immediately, mult_busy=0, following mflo accepted first cycle.
REQ-030 Bench with DECODE_ILLEGAL_TRAP_EN: opcode 0x3F -> illegal=1, alu 0; without macro same word -> flag_i 1, alu 2.
